// File: rtl/ex_iter_pkg.sv
// Shared definitions for the execute stage: aluop/alusel encodings,
// reset level, zero word and the divider state encoding.
package ex_iter_pkg;

    localparam int unsigned ALUOP_W  = 8;
    localparam int unsigned ALUSEL_W = 3;

    localparam logic        RstEnable = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Result classes
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

    // Operations
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [ALUOP_W-1:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [ALUOP_W-1:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [ALUOP_W-1:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [ALUOP_W-1:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [ALUOP_W-1:0] EXE_MTLO_OP  = 8'b0001_0011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_iter_div.sv
// Iterative restoring divider, one quotient bit per cycle.
// Ports: clk, rst (async active-low); start/is_signed/opa/opb launch a
// divide from IDLE; abort returns to IDLE from any state. busy marks the
// iteration cycles, done the single result cycle carrying quotient/remainder.
module div_iter
    import ex_iter_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_signed,
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(W) + 1;

    div_state_e       state_q, state_d;
    logic [W-1:0]     rem_q, quot_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quot_q, neg_rem_q;

    logic [W-1:0] opa_abs, opb_abs;
    logic         div_zero, last_step;
    logic [W:0]   shifted, trial;

    assign opa_abs   = (is_signed && opa[W-1]) ? (~opa + W'(1)) : opa;
    assign opb_abs   = (is_signed && opb[W-1]) ? (~opb + W'(1)) : opb;
    assign div_zero  = (opb == '0);
    assign last_step = (cnt_q == CNT_W'(W - 1));

    // Dividend bits shift out of the top of quot_q into the partial remainder
    assign shifted = {rem_q, quot_q[W-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) state_q <= DIV_IDLE;
        else                  state_q <= state_d;
    end

    // Next state and status decode
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            DIV_IDLE: if (start) state_d = div_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                busy = 1'b1;
                if (last_step) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                done    = 1'b1;
                state_d = DIV_IDLE;
            end
            default:  state_d = DIV_IDLE;
        endcase
        if (abort) state_d = DIV_IDLE;
    end

    // Operand capture and restoring iteration
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rem_q      <= '0;
            quot_q     <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (!abort) begin
            if (state_q == DIV_IDLE && start) begin
                cnt_q <= '0;
                dvs_q <= opb_abs;
                if (div_zero) begin
                    // Divide-by-zero result is delivered raw, no sign fixup
                    quot_q     <= '1;
                    rem_q      <= opa;
                    neg_quot_q <= 1'b0;
                    neg_rem_q  <= 1'b0;
                end else begin
                    quot_q     <= opa_abs;
                    rem_q      <= '0;
                    neg_quot_q <= is_signed & (opa[W-1] ^ opb[W-1]);
                    neg_rem_q  <= is_signed & opa[W-1];
                end
            end else if (state_q == DIV_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (!trial[W]) begin
                    rem_q  <= trial[W-1:0];
                    quot_q <= {quot_q[W-2:0], 1'b1};
                end else begin
                    rem_q  <= shifted[W-1:0];
                    quot_q <= {quot_q[W-2:0], 1'b0};
                end
            end
        end
    end

    // Sign fixup: quotient negative on sign mismatch, remainder follows dividend
    assign quotient  = neg_quot_q ? (~quot_q + W'(1)) : quot_q;
    assign remainder = neg_rem_q  ? (~rem_q  + W'(1)) : rem_q;

endmodule

// File: rtl/ex_iter.sv
// Execute stage: combinational logic/shift/arith/multiply/move ALU plus an
// iterative divider that stalls the pipeline.
// Ports: clk, rst (async active-low), flush_i; alusel_i/aluop_i select the
// operation on reg1_data_i/reg2_data_i; waddr_i/wreg_i destination; hi_i/lo_i
// forwarded HI/LO. Outputs GPR writeback (wreg_o/waddr_o/wdata_o), HI/LO
// writeback (whilo_o/hi_o/lo_o) and stallreq_o.
module ex_iter
    import ex_iter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned OP_W   = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [SEL_W-1:0]  alusel_i,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic              wreg_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   a, b, alu_res, div_quot, div_rem;
    logic [SH_W-1:0]     shamt;
    logic [2*DATA_W-1:0] mul_s, mul_u;
    logic                is_div, is_mul, is_mt, div_busy, div_done;

    assign a     = reg1_data_i;
    assign b     = reg2_data_i;
    assign shamt = a[SH_W-1:0];

    assign is_div = (aluop_i == OP_W'(EXE_DIV_OP))  || (aluop_i == OP_W'(EXE_DIVU_OP));
    assign is_mul = (aluop_i == OP_W'(EXE_MULT_OP)) || (aluop_i == OP_W'(EXE_MULTU_OP));
    assign is_mt  = (aluop_i == OP_W'(EXE_MTHI_OP)) || (aluop_i == OP_W'(EXE_MTLO_OP));

    // Full-width products; signed form uses explicit sign extension
    assign mul_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    assign mul_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    div_iter #(.W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div & ~flush_i),
        .is_signed (aluop_i == OP_W'(EXE_DIV_OP)),
        .opa       (a),
        .opb       (b),
        .abort     (flush_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // GPR result, selected by class then operation
    always_comb begin
        alu_res = DATA_W'(ZeroWord);
        case (alusel_i)
            SEL_W'(EXE_RES_LOGIC): case (aluop_i)
                OP_W'(EXE_OR_OP):  alu_res = a | b;
                OP_W'(EXE_AND_OP): alu_res = a & b;
                OP_W'(EXE_XOR_OP): alu_res = a ^ b;
                OP_W'(EXE_NOR_OP): alu_res = ~(a | b);
                default: ;
            endcase
            SEL_W'(EXE_RES_SHIFT): case (aluop_i)
                OP_W'(EXE_SLL_OP): alu_res = b << shamt;
                OP_W'(EXE_SRL_OP): alu_res = b >> shamt;
                OP_W'(EXE_SRA_OP): alu_res = DATA_W'($signed(b) >>> shamt);
                default: ;
            endcase
            SEL_W'(EXE_RES_ARITH): case (aluop_i)
                OP_W'(EXE_ADDU_OP): alu_res = a + b;
                OP_W'(EXE_SUBU_OP): alu_res = a - b;
                OP_W'(EXE_SLT_OP):  alu_res = DATA_W'($signed(a) < $signed(b));
                OP_W'(EXE_SLTU_OP): alu_res = DATA_W'(a < b);
                default: ;
            endcase
            SEL_W'(EXE_RES_MOVE): case (aluop_i)
                OP_W'(EXE_MFHI_OP): alu_res = hi_i;
                OP_W'(EXE_MFLO_OP): alu_res = lo_i;
                default: ;
            endcase
            default: ;
        endcase
    end

    // Writeback, HI/LO request and stall; everything held at zero in reset
    always_comb begin
        wreg_o     = 1'b0;
        waddr_o    = '0;
        wdata_o    = DATA_W'(ZeroWord);
        whilo_o    = 1'b0;
        hi_o       = DATA_W'(ZeroWord);
        lo_o       = DATA_W'(ZeroWord);
        stallreq_o = 1'b0;
        if (rst != RstEnable) begin
            waddr_o = waddr_i;
            wdata_o = alu_res;
            wreg_o  = wreg_i & ~(is_mul | is_div | is_mt) & ~flush_i;
            if (div_done) begin
                whilo_o = 1'b1;
                hi_o    = div_rem;
                lo_o    = div_quot;
            end else begin
                case (aluop_i)
                    OP_W'(EXE_MULT_OP):  begin whilo_o = 1'b1; {hi_o, lo_o} = mul_s; end
                    OP_W'(EXE_MULTU_OP): begin whilo_o = 1'b1; {hi_o, lo_o} = mul_u; end
                    OP_W'(EXE_MTHI_OP):  begin whilo_o = 1'b1; hi_o = a; lo_o = lo_i; end
                    OP_W'(EXE_MTLO_OP):  begin whilo_o = 1'b1; hi_o = hi_i; lo_o = a; end
                    default: ;
                endcase
            end
            // Stall from the issuing IDLE cycle through the last iteration
            stallreq_o = (is_div & ~div_busy & ~div_done) | div_busy;
            if (flush_i) begin
                whilo_o    = 1'b0;
                stallreq_o = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_iter.sv
// Randomised self-checking bench for ex_iter (DATA_W=32) with directed cases.
module tb_ex_iter;
    import ex_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  alusel_i = '0;
    logic [7:0]  aluop_i = '0;
    logic [31:0] reg1_data_i = '0, reg2_data_i = '0, hi_i = '0, lo_i = '0;
    logic [4:0]  waddr_i = '0;
    logic        wreg_i = 1'b0;
    logic        wreg_o, whilo_o, stallreq_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, hi_o, lo_o;

    ex_iter dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .alusel_i(alusel_i), .aluop_i(aluop_i),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .waddr_i(waddr_i),
        .wreg_i(wreg_i), .hi_i(hi_i), .lo_i(lo_i), .wreg_o(wreg_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference results straight from the instruction definitions
    function automatic void ref_alu(
        input  logic [7:0]  op, input logic [2:0] sel,
        input  logic [31:0] x, y, hi, lo, input logic wr,
        output logic [31:0] wd, output logic wh, output logic [31:0] eh, el,
        output logic ewr
    );
        longint      ps;
        logic [63:0] p;
        wd = 0; wh = 0; eh = 0; el = 0;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)  wd = x | y;
            if (op == EXE_AND_OP) wd = x & y;
            if (op == EXE_XOR_OP) wd = x ^ y;
            if (op == EXE_NOR_OP) wd = ~(x | y);
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) wd = y << x[4:0];
            if (op == EXE_SRL_OP) wd = y >> x[4:0];
            if (op == EXE_SRA_OP) wd = 32'($signed(y) >>> x[4:0]);
        end else if (sel == EXE_RES_ARITH) begin
            if (op == EXE_ADDU_OP) wd = x + y;
            if (op == EXE_SUBU_OP) wd = x - y;
            if (op == EXE_SLT_OP)  wd = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            if (op == EXE_SLTU_OP) wd = (x < y) ? 32'd1 : 32'd0;
        end else if (sel == EXE_RES_MOVE) begin
            if (op == EXE_MFHI_OP) wd = hi;
            if (op == EXE_MFLO_OP) wd = lo;
        end
        if (op == EXE_MULT_OP) begin
            ps = longint'(int'(x)) * longint'(int'(y));
            p = ps; wh = 1; eh = p[63:32]; el = p[31:0];
        end
        if (op == EXE_MULTU_OP) begin
            p = {32'd0, x} * {32'd0, y}; wh = 1; eh = p[63:32]; el = p[31:0];
        end
        if (op == EXE_MTHI_OP) begin wh = 1; eh = x; el = lo; end
        if (op == EXE_MTLO_OP) begin wh = 1; eh = hi; el = x; end
        ewr = wr && !(op inside {EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP, EXE_DIVU_OP,
                                 EXE_MTHI_OP, EXE_MTLO_OP});
    endfunction

    function automatic void div_ref(input logic [7:0] op, input logic [31:0] x, y,
                                    output logic [31:0] q, r);
        longint sq, sr;
        if (y == 0) begin
            q = '1; r = x;
        end else if (op == EXE_DIV_OP) begin
            sq = longint'(int'(x)) / longint'(int'(y));
            sr = longint'(int'(x)) % longint'(int'(y));
            q = sq[31:0]; r = sr[31:0];
        end else begin
            q = x / y; r = x % y;
        end
    endfunction

    // Divider occupancy: dv_k = cycles since issue (-1 when idle), result on cycle dv_len
    int          dv_k = -1;
    int          dv_len = 0;
    logic [31:0] dv_q, dv_r;
    logic [31:0] m_wd, m_hi, m_lo;
    logic        m_wh, m_wr, m_st, m_isdiv;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_wreg", 64'(wreg_o), 0);     check("rst_waddr", 64'(waddr_o), 0);
            check("rst_wdata", 64'(wdata_o), 0);   check("rst_whilo", 64'(whilo_o), 0);
            check("rst_hi", 64'(hi_o), 0);         check("rst_lo", 64'(lo_o), 0);
            check("rst_stall", 64'(stallreq_o), 0);
            dv_k = -1;
        end else begin
            ref_alu(aluop_i, alusel_i, reg1_data_i, reg2_data_i, hi_i, lo_i, wreg_i,
                    m_wd, m_wh, m_hi, m_lo, m_wr);
            m_isdiv = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
            m_st = 0;
            if (flush_i) begin
                m_wr = 0; m_wh = 0;
            end else if (dv_k < 0) begin
                if (m_isdiv) m_st = 1;
            end else if (dv_k < dv_len) begin
                m_st = 1;
            end else begin
                m_wh = 1; m_hi = dv_r; m_lo = dv_q;
            end
            check("m_stall", 64'(stallreq_o), 64'(m_st));
            check("m_wreg", 64'(wreg_o), 64'(m_wr));
            check("m_waddr", 64'(waddr_o), 64'(waddr_i));
            check("m_whilo", 64'(whilo_o), 64'(m_wh));
            if (!flush_i) check("m_wdata", 64'(wdata_o), 64'(m_wd));
            if (m_wh) begin
                check("m_hi", 64'(hi_o), 64'(m_hi));
                check("m_lo", 64'(lo_o), 64'(m_lo));
            end
            if (flush_i) dv_k = -1;
            else if (dv_k < 0) begin
                if (m_isdiv) begin
                    div_ref(aluop_i, reg1_data_i, reg2_data_i, dv_q, dv_r);
                    dv_len = (reg2_data_i == 0) ? 1 : 33;
                    dv_k = 1;
                end
            end else if (dv_k == dv_len) dv_k = -1;
            else dv_k++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] x, y,
                         input logic wr, input logic [4:0] wa);
        aluop_i = op; alusel_i = sel; reg1_data_i = x; reg2_data_i = y;
        wreg_i = wr; waddr_i = wa; flush_i = 0;
    endtask

    task automatic run_div(input logic [7:0] op, input logic [31:0] x, y,
                           input int exp_stall, input logic [31:0] exp_lo, exp_hi);
        int cnt = 0;
        next();
        drive(op, EXE_RES_NOP, x, y, 1'b1, 5'd3);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stallreq_o) cnt++;
            else break;
        end
        check("div_stall_cycles", 64'(cnt), 64'(exp_stall));
        check("div_whilo", 64'(whilo_o), 1);
        check("div_lo", 64'(lo_o), 64'(exp_lo));
        check("div_hi", 64'(hi_o), 64'(exp_hi));
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom % 64);
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic pick(input int idx, output logic [7:0] op, output logic [2:0] sel);
        case (idx)
            0: begin op = EXE_OR_OP;    sel = EXE_RES_LOGIC; end
            1: begin op = EXE_AND_OP;   sel = EXE_RES_LOGIC; end
            2: begin op = EXE_XOR_OP;   sel = EXE_RES_LOGIC; end
            3: begin op = EXE_NOR_OP;   sel = EXE_RES_LOGIC; end
            4: begin op = EXE_SLL_OP;   sel = EXE_RES_SHIFT; end
            5: begin op = EXE_SRL_OP;   sel = EXE_RES_SHIFT; end
            6: begin op = EXE_SRA_OP;   sel = EXE_RES_SHIFT; end
            7: begin op = EXE_ADDU_OP;  sel = EXE_RES_ARITH; end
            8: begin op = EXE_SUBU_OP;  sel = EXE_RES_ARITH; end
            9: begin op = EXE_SLT_OP;   sel = EXE_RES_ARITH; end
            10: begin op = EXE_SLTU_OP; sel = EXE_RES_ARITH; end
            11: begin op = EXE_MFHI_OP; sel = EXE_RES_MOVE;  end
            12: begin op = EXE_MFLO_OP; sel = EXE_RES_MOVE;  end
            13: begin op = EXE_MULT_OP; sel = EXE_RES_NOP;   end
            14: begin op = EXE_MULTU_OP; sel = EXE_RES_NOP;  end
            15: begin op = EXE_MTHI_OP; sel = EXE_RES_NOP;   end
            16: begin op = EXE_MTLO_OP; sel = EXE_RES_NOP;   end
            17: begin op = EXE_DIV_OP;  sel = EXE_RES_NOP;   end
            18: begin op = EXE_DIVU_OP; sel = EXE_RES_NOP;   end
            default: begin
                op = 8'($urandom); sel = 3'($urandom);
                if (op == EXE_DIV_OP || op == EXE_DIVU_OP) op = EXE_NOP_OP;
            end
        endcase
    endtask

    initial begin
        logic [7:0] op;
        logic [2:0] sel;
        int len, fat;

        repeat (3) @(posedge clk);
        #1 rst = 1;

        // Same-cycle single-cycle operations
        drive(EXE_OR_OP, EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, 5'd5);
        @(negedge clk);
        check("or_wdata", 64'(wdata_o), 64'h0F0F_00FF);
        check("or_wreg", 64'(wreg_o), 1);
        check("or_waddr", 64'(waddr_o), 5);
        check("or_stall", 64'(stallreq_o), 0);
        next(); drive(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd6);
        @(negedge clk); check("sra_wdata", 64'(wdata_o), 64'hF800_0000);
        next(); drive(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd7);
        @(negedge clk); check("slt_wdata", 64'(wdata_o), 1);
        next(); drive(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd7);
        @(negedge clk); check("sltu_wdata", 64'(wdata_o), 0);
        next(); drive(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd8);
        @(negedge clk);
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);
        check("mult_whilo", 64'(whilo_o), 1);
        check("mult_wreg", 64'(wreg_o), 0);
        next(); drive(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd8);
        @(negedge clk);
        check("multu_hi", 64'(hi_o), 2);
        check("multu_lo", 64'(lo_o), 64'hFFFF_FFFA);
        next(); drive(8'hFF, EXE_RES_LOGIC, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 5'd9);
        @(negedge clk);
        check("unk_wdata", 64'(wdata_o), 0);
        check("unk_whilo", 64'(whilo_o), 0);

        // Divides, back to back
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div(EXE_DIVU_OP, 32'h1234_5678, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234_5678);
        run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);

        // Flush at iteration count 10
        next(); drive(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd3, 1'b0, 5'd1);
        repeat (11) next();
        flush_i = 1;
        @(negedge clk);
        check("flush_stall", 64'(stallreq_o), 0);
        check("flush_whilo", 64'(whilo_o), 0);
        check("flush_wreg", 64'(wreg_o), 0);
        next(); drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        check("post_flush_stall", 64'(stallreq_o), 0);
        check("post_flush_whilo", 64'(whilo_o), 0);

        // Asynchronous reset mid-iteration, then a clean divide
        next(); drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd9, 1'b1, 5'd2);
        repeat (5) next();
        #2 rst = 0;
        #1;
        check("arst_stall", 64'(stallreq_o), 0);
        check("arst_waddr", 64'(waddr_o), 0);
        check("arst_whilo", 64'(whilo_o), 0);
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
        repeat (2) next();
        rst = 1;
        run_div(EXE_DIV_OP, 32'd1000, 32'd9, 33, 32'd111, 32'd1);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            next();
            pick(int'($urandom % 20), op, sel);
            drive(op, sel, rand_opnd(), rand_opnd(), 1'($urandom), 5'($urandom));
            hi_i = $urandom; lo_i = $urandom;
            if (op == EXE_DIV_OP || op == EXE_DIVU_OP) begin
                len = (reg2_data_i == 0) ? 1 : 33;
                fat = ($urandom % 4 == 0) ? int'($urandom_range(0, len)) : -1;
                for (int k = 0; k <= len; k++) begin
                    if (k > 0) begin
                        next();
                        reg1_data_i = rand_opnd(); reg2_data_i = rand_opnd();
                    end
                    flush_i = (k == fat);
                    if (flush_i) break;
                end
            end else begin
                flush_i = ($urandom % 16 == 0);
            end
        end

        next(); drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
        repeat (3) next();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_iter.md
Name: ex_iter

Overview:
- Parametrised next-generation execute stage for the in-order MIPS-style pipeline. It sits between the id/ex and ex/mem pipeline registers.
- Performs single-cycle logic, shift, add/sub and multiply operations combinationally.
- Performs signed and unsigned division with an iterative restoring divider that stalls the pipeline through `stallreq_o`.
- Produces a GPR writeback and a HI/LO writeback request.

Parameters:
- DATA_W, 32, operand/result width (even, ≥8)
- ADDR_W, 5, register address width
- OP_W, 8, aluop field width
- SEL_W, 3, alusel field width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-low reset
- flush_i  in  1  annul the instruction in EX, abort any division
- alusel_i  in  SEL_W  result class: LOGIC, SHIFT, ARITH, MOVE, NOP
- aluop_i  in  OP_W  operation: OR, AND, XOR, NOR, SLL, SRL, SRA, ADDU, SUBU, SLT, SLTU, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO
- reg1_data_i  in  DATA_W  operand A / dividend
- reg2_data_i  in  DATA_W  operand B / divisor; shift amount = low log2(DATA_W) bits of A
- waddr_i  in  ADDR_W  destination GPR
- wreg_i  in  1  GPR write enable
- hi_i, lo_i  in  DATA_W  current HI/LO, already forwarded
- wreg_o  out  1  GPR write enable to mem
- waddr_o  out  ADDR_W  GPR address to mem
- wdata_o  out  DATA_W  GPR data to mem
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  DATA_W  HI/LO write data
- stallreq_o  out  1  hold IF/ID/EX, bubble into MEM

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; counter, partial remainder and quotient registers cleared.
  - All outputs 0 while rst=0.
- Single-cycle ops are combinational, zero latency:
  - Logic: bitwise operations.
  - Shifts: SRA sign-extends.
  - ADDU/SUBU: wrap modulo 2^DATA_W.
  - SLT/SLTU: result is 1 or 0, zero-extended.
  - MULT/MULTU: 2*DATA_W product; hi_o = upper half, lo_o = lower half, whilo_o=1, wreg_o=0.
  - MTHI/MTLO: write operand A to HI or LO; the other half passes through from hi_i/lo_i; whilo_o=1.
  - MFHI/MFLO: wdata_o = hi_i / lo_i.
- Pass-through and defaults:
  - waddr_o = waddr_i.
  - wreg_o = wreg_i, forced 0 for MULT*/DIV*/MT*.
  - Unknown aluop/alusel gives wdata_o=0 and whilo_o=0.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE with aluop DIV/DIVU and flush_i=0: stallreq_o=1 combinationally.
    - Divisor≠0: capture operand magnitudes (two's-complement abs for DIV) and sign flags, count=0, go to BUSY.
    - Divisor=0: go straight to DONE with quotient = all-ones, remainder = dividend (raw operand).
  - BUSY: one restoring step per cycle (shift, trial subtract, set quotient bit); stallreq_o=1; after DATA_W steps go to DONE.
  - DONE: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder, then IDLE next edge (the pipeline advances on that same edge).
    - Signed fixup: quotient negated if operand signs differ; remainder takes dividend sign.
  - Latency: divider asserts stallreq_o for DATA_W+1 cycles (1 cycle for divide-by-zero). The instruction occupies EX for DATA_W+2 cycles.
  - whilo_o=0 for DIV/DIVU in IDLE/BUSY.
- flush_i=1: FSM to IDLE next edge from any state; stallreq_o=0, wreg_o=0, whilo_o=0 in that cycle; no partial HI/LO write.
- Operands change while BUSY: ignored, because captured values are used.
- Back-to-back DIV: the second DIV seen in IDLE the cycle after DONE starts a fresh operation.
- Signed edge case: DIV of most-negative by -1 gives quotient = most-negative (wrap), remainder 0.

Decomposition:
- Shared package (project defines file):
  - aluop/alusel encodings.
  - RstEnable = 1'b0.
  - ZeroWord.
  - Divider state encoding.
- One sub-module: `div_iter`, containing the FSM, counter, restoring datapath and sign fixup.
  - Interface: start, signed, opa, opb, abort → busy, done, quotient, remainder.
- ex_iter keeps the combinational ALU, muxing and stall logic.

Test Plan (DATA_W=32):
- OR 0x0F0F0000 | 0x000000FF, alusel LOGIC, wreg_i=1, waddr 5 → same-cycle wdata_o=0x0F0F00FF, wreg_o=1, waddr_o=5, stallreq_o=0.
- SRA A=4, B=0x80000000 → 0xF8000000. SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0.
- MULT 0xFFFFFFFE × 3 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, whilo_o=1, wreg_o=0. MULTU same operands → hi_o=2, lo_o=0xFFFFFFFA.
- DIV -7/2 held constant → stallreq_o high 33 cycles, then DONE cycle with lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1. DIVU 100/7 → lo_o=14, hi_o=2.
- DIVU x/0 → stallreq_o for 1 cycle, then lo_o=0xFFFFFFFF, hi_o=x.
- DIV started, flush_i pulsed at BUSY count 10 → next cycle IDLE, stallreq_o=0, no whilo_o pulse. Separately, rst low mid-BUSY → all outputs 0 immediately and clean restart of the next DIV.
